dma_priority_resolver: RTL and testbench
========================================

Name: dma_priority_resolver

Overview:
- Channel-request front end of the DMA controller. It sits directly upstream of the timing-and-control stage.
- Synchronises the four external DREQ lines and applies the mask register and the DREQ-sense setting.
- Arbitrates among pending channels with fixed or rotating priority, then holds the winner for one service cycle.
- Drives DACK[3:0] for the held winner while timing-and-control asserts assertDACK. Timing-and-control starts a cycle from requestPending, not from raw DREQ.

Parameters:
- NUM_CH, 4, number of DMA channels; only 4 is supported.
- SYNC_STAGES, 2, flop depth of the DREQ synchroniser; minimum 2.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  NUM_CH  external channel requests, asynchronous to CLK.
- maskReg  in  NUM_CH  per-channel mask; 1 = channel ignored.
- cmdDisable  in  1  command-register controller disable; 1 = no arbitration.
- cmdRotPri  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
- cmdDreqSenseLow  in  1  1 = DREQ is active-low.
- cmdDackSenseHigh  in  1  1 = DACK is active-high.
- lockReq  in  1  one-cycle pulse from timing-and-control at S1 entry; capture the current winner.
- assertDACK  in  1  timing-and-control DACK enable (S1/S2).
- serviceDone  in  1  one-cycle pulse from timing-and-control at S4; release the lock.
- intEOP  in  1  terminal count for the active channel; qualified with serviceDone.
- requestPending  out  1  at least one unmasked, enabled request is present and the block is idle.
- activeChannel  out  2  index of the held winner.
- channelValid  out  1  1 while a winner is held.
- DACK  out  NUM_CH  channel acknowledge, polarity set by cmdDackSenseHigh.

Behaviour:
- Reset (async, RESET_N low):
  - State goes to IDLE.
  - Priority pointer ptr = 0.
  - Synchroniser flops are cleared to the inactive level.
  - activeChannel = 0, channelValid = 0, requestPending = 0.
  - DACK sits at the inactive level: 4'b0000 if cmdDackSenseHigh = 1, else 4'b1111.
  - Reset mid-service aborts immediately with no pending state retained.
- Synchroniser:
  - reqSync = SYNC_STAGES-flop copy of (DREQ XOR {4{cmdDreqSenseLow}}).
  - A DREQ edge reaches requestPending after SYNC_STAGES cycles.
- Effective request: eff = reqSync & ~maskReg & {4{~cmdDisable}}.
- requestPending = (state == IDLE) && |eff. This is combinational from registers.
- Arbitration: the winner is the first set bit of eff, scanning channels ptr, ptr+1, ... with modulo-4 wrap.
- State machine (one-hot, two states):
  - IDLE: lockReq && |eff → LOCKED. This captures activeChannel = winner and sets channelValid = 1 on the next edge.
  - IDLE: lockReq with eff == 0 → ignored; stay IDLE, channelValid stays 0.
  - LOCKED: serviceDone → IDLE; channelValid = 0 on the next edge.
  - LOCKED: if cmdRotPri = 1, ptr ← (activeChannel + 1) mod 4 on serviceDone, so the serviced channel becomes lowest priority.
  - LOCKED: if cmdRotPri = 0, ptr ← 0.
  - LOCKED: lockReq is ignored.
  - lockReq and serviceDone in the same LOCKED cycle: serviceDone wins.
  - serviceDone in IDLE is ignored.
- While LOCKED:
  - DREQ deassertion, mask changes and cmdDisable do not drop the lock.
  - They take effect at the next arbitration.
- DACK:
  - Active value is onehot(activeChannel) when LOCKED && assertDACK, else 0.
  - The pin value is the active value XOR {4{~cmdDackSenseHigh}}.
  - Combinational from the state register and assertDACK. The active value is never multi-hot.

Optional Feature:
- Macro: DMA_SW_REQUEST_EN.
- With the macro defined, three extra ports are added:
  - swReqWrite  in  1.
  - swReqData  in  3: bit2 = set/clear, bits1:0 = channel.
  - swReqReg  out  4.
- swReqReg behaviour:
  - Written on a swReqWrite cycle.
  - Bits are cleared on reset.
  - The active channel's bit is cleared on serviceDone && intEOP.
- eff becomes ((reqSync & ~maskReg) | swReqReg) & {4{~cmdDisable}}. Software requests bypass the mask and the synchroniser.
- Without the macro, none of these ports or the register exist.

Decomposition:
- Package dma_pkg:
  - NUM_CH.
  - typedef chIdx_t (logic [1:0]).
  - typedef chVec_t (logic [NUM_CH-1:0]).
  - One-hot state enum with index constants.
  - Function rotPriWinner(chVec_t req, chIdx_t ptr) returning chIdx_t.
- Sub-module dreq_sync: parameterised multi-bit flop synchroniser with async active-low reset.

Test Plan:
- Reset: RESET_N=0 with DREQ=4'b1111, cmdDackSenseHigh=0 → DACK=4'b1111, requestPending=0, channelValid=0. After release, requestPending=1 two cycles later.
- Fixed priority: DREQ=4'b1010, cmdRotPri=0, lockReq pulse → activeChannel=1. With assertDACK=1, DACK=4'b0010 at cmdDackSenseHigh=1.
- Rotation: cmdRotPri=1, DREQ=4'b1111. Serve ch0, then ch1, then ch2, each closed with serviceDone → winners 0,1,2,3,0 across successive locks.
- Mask and disable: maskReg=4'b0001, DREQ=4'b0001 → requestPending=0. Then cmdDisable=1 with DREQ=4'b0100 → requestPending=0 and lockReq ignored.
- Mid-service events: after lock on ch2, drop DREQ[2] and set maskReg[2] → channelValid stays 1 until serviceDone. Simultaneous lockReq+serviceDone → IDLE.
- Async reset while LOCKED with assertDACK=1 → DACK goes inactive in the same cycle, ptr=0, and the next arbitration with DREQ=4'b1000 grants ch3.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared channel types, FSM state encoding and the rotating-priority scan
package dma_pkg;
    localparam int NUM_CH = 4;

    typedef logic [1:0]        chIdx_t;
    typedef logic [NUM_CH-1:0] chVec_t;

    localparam int IDLE_IDX   = 0;
    localparam int LOCKED_IDX = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    // First set bit of req scanning ptr, ptr+1, ... with wrap; reverse loop lets the nearest one win
    function automatic chIdx_t rotPriWinner(chVec_t req, chIdx_t ptr);
        chIdx_t w;
        chIdx_t idx;
        w = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + chIdx_t'(i);
            if (req[idx]) w = idx;
        end
        return w;
    endfunction
endpackage

// File: rtl/dma_priority_resolver_dreq_sync.sv
// dreq_sync: multi-bit flop-chain synchroniser, cleared to zero on async active-low reset
module dreq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync_q [STAGES];

    // shift the sampled input one stage down the chain per cycle
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // chain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: DREQ sync/mask, fixed or rotating arbitration, winner lock and DACK drive.
// Channel count comes from dma_pkg::NUM_CH (4 only). Define DMA_SW_REQUEST_EN to add the
// software request register and its swReqWrite/swReqData/swReqReg ports.
module dma_priority_resolver
    import dma_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              cmdDisable,
    input  logic              cmdRotPri,
    input  logic              cmdDreqSenseLow,
    input  logic              cmdDackSenseHigh,
    input  logic              lockReq,
    input  logic              assertDACK,
    input  logic              serviceDone,
    input  logic              intEOP,
    output logic              requestPending,
    output logic [1:0]        activeChannel,
    output logic              channelValid,
    output logic [NUM_CH-1:0] DACK
`ifdef DMA_SW_REQUEST_EN
    ,
    input  logic              swReqWrite,
    input  logic [2:0]        swReqData,
    output logic [NUM_CH-1:0] swReqReg
`endif
);
    state_t state_q, state_d;
    chIdx_t ptr_q, ptr_d;
    chIdx_t active_q, active_d;
    logic   valid_q, valid_d;
    chVec_t req_sync;
    chVec_t eff;
    chVec_t dack_act;
    chIdx_t winner;

    dreq_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (CLK),
        .rst_n(RESET_N),
        .d    (DREQ ^ {NUM_CH{cmdDreqSenseLow}}),
        .q    (req_sync)
    );

`ifdef DMA_SW_REQUEST_EN
    chVec_t sw_req_d, sw_req_q;

    // software requests: terminal count retires the active channel's bit, a write then overrides
    always_comb begin
        sw_req_d = sw_req_q;
        if (state_q[LOCKED_IDX] && serviceDone && intEOP) sw_req_d[active_q] = 1'b0;
        if (swReqWrite) sw_req_d[swReqData[1:0]] = swReqData[2];
    end

    // software request register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) sw_req_q <= '0;
        else          sw_req_q <= sw_req_d;
    end

    assign swReqReg = sw_req_q;
    assign eff      = ((req_sync & ~maskReg) | sw_req_q) & {NUM_CH{~cmdDisable}};
`else
    logic unused_eop;
    assign unused_eop = intEOP;
    assign eff        = req_sync & ~maskReg & {NUM_CH{~cmdDisable}};
`endif

    assign winner = rotPriWinner(eff, ptr_q);

    // lock the winner on lockReq from IDLE; serviceDone releases and advances the pointer
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        valid_d  = valid_q;
        if (state_q[IDLE_IDX] && lockReq && |eff) begin
            state_d  = ST_LOCKED;
            active_d = winner;
            valid_d  = 1'b1;
        end else if (state_q[LOCKED_IDX] && serviceDone) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            ptr_d   = cmdRotPri ? active_q + 2'd1 : 2'd0;
        end
    end

    // arbitration state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    assign dack_act       = (state_q[LOCKED_IDX] && assertDACK) ? chVec_t'(1) << active_q : '0;
    assign DACK           = dack_act ^ {NUM_CH{~cmdDackSenseHigh}};
    assign requestPending = state_q[IDLE_IDX] && |eff;
    assign activeChannel  = active_q;
    assign channelValid   = valid_q;
endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb_dma_priority_resolver: directed checks of sync latency, priority modes, masking, lock hold and async reset
module tb_dma_priority_resolver;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       cmdDisable, cmdRotPri, cmdDreqSenseLow, cmdDackSenseHigh;
    logic       lockReq, assertDACK, serviceDone, intEOP;
    logic       requestPending, channelValid;
    logic [1:0] activeChannel;
    logic [3:0] DACK;
`ifdef DMA_SW_REQUEST_EN
    logic       swReqWrite = 1'b0;
    logic [2:0] swReqData  = 3'b000;
    logic [3:0] swReqReg;
`endif

    int checks = 0;
    int errors = 0;

    dma_priority_resolver #(.SYNC_STAGES(2)) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .DREQ            (DREQ),
        .maskReg         (maskReg),
        .cmdDisable      (cmdDisable),
        .cmdRotPri       (cmdRotPri),
        .cmdDreqSenseLow (cmdDreqSenseLow),
        .cmdDackSenseHigh(cmdDackSenseHigh),
        .lockReq         (lockReq),
        .assertDACK      (assertDACK),
        .serviceDone     (serviceDone),
        .intEOP          (intEOP),
        .requestPending  (requestPending),
        .activeChannel   (activeChannel),
        .channelValid    (channelValid),
        .DACK            (DACK)
`ifdef DMA_SW_REQUEST_EN
        ,
        .swReqWrite      (swReqWrite),
        .swReqData       (swReqData),
        .swReqReg        (swReqReg)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic lock_pulse();
        lockReq = 1'b1;
        step(1);
        lockReq = 1'b0;
    endtask

    task automatic done_pulse();
        serviceDone = 1'b1;
        step(1);
        serviceDone = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; DREQ = 4'b1111; maskReg = 4'b0000;
        cmdDisable = 1'b0; cmdRotPri = 1'b0; cmdDreqSenseLow = 1'b0; cmdDackSenseHigh = 1'b0;
        lockReq = 1'b0; assertDACK = 1'b0; serviceDone = 1'b0; intEOP = 1'b0;
        step(2);
        check("rst_dack", DACK, 4'b1111);
        check("rst_rp", requestPending, 1'b0);
        check("rst_cv", channelValid, 1'b0);
        check("rst_ac", activeChannel, 2'd0);
        RESET_N = 1'b1;
        step(1);
        check("sync_1cyc_rp", requestPending, 1'b0);
        step(1);
        check("sync_2cyc_rp", requestPending, 1'b1);

        cmdDackSenseHigh = 1'b1;
        DREQ = 4'b1010;
        step(2);
        check("fix_rp", requestPending, 1'b1);
        lock_pulse();
        check("fix_cv", channelValid, 1'b1);
        check("fix_ac", activeChannel, 2'd1);
        check("fix_rp_locked", requestPending, 1'b0);
        check("fix_dack_off", DACK, 4'b0000);
        assertDACK = 1'b1;
        #1 check("fix_dack_hi", DACK, 4'b0010);
        cmdDackSenseHigh = 1'b0;
        #1 check("fix_dack_lo", DACK, 4'b1101);
        cmdDackSenseHigh = 1'b1;
        assertDACK = 1'b0;
        step(1);
        done_pulse();
        check("fix_release_cv", channelValid, 1'b0);

        cmdRotPri = 1'b1;
        DREQ = 4'b1111;
        step(2);
        for (int k = 0; k < 5; k++) begin
            lock_pulse();
            check($sformatf("rot_ac%0d", k), activeChannel, k % 4);
            done_pulse();
        end

        maskReg = 4'b0001;
        DREQ = 4'b0001;
        step(2);
        check("mask_rp", requestPending, 1'b0);
        lock_pulse();
        check("mask_lock_ign", channelValid, 1'b0);
        maskReg = 4'b0000;
        cmdDisable = 1'b1;
        DREQ = 4'b0100;
        step(2);
        check("dis_rp", requestPending, 1'b0);
        lock_pulse();
        check("dis_lock_ign", channelValid, 1'b0);
        cmdDisable = 1'b0;
        #1 check("enable_rp", requestPending, 1'b1);

        cmdRotPri = 1'b0;
        step(1);
        lock_pulse();
        check("mid_ac", activeChannel, 2'd2);
        DREQ = 4'b0000;
        maskReg = 4'b0100;
        cmdDisable = 1'b1;
        step(3);
        check("mid_hold_cv", channelValid, 1'b1);
        check("mid_hold_ac", activeChannel, 2'd2);
        lockReq = 1'b1;
        serviceDone = 1'b1;
        step(1);
        lockReq = 1'b0;
        serviceDone = 1'b0;
        check("both_idle_cv", channelValid, 1'b0);
        cmdDisable = 1'b0;
        maskReg = 4'b0000;
        DREQ = 4'b1001;
        step(2);
        lock_pulse();
        check("fix_ptr0_ac", activeChannel, 2'd0);
        assertDACK = 1'b1;
        #1 check("dack_ch0", DACK, 4'b0001);
        assertDACK = 1'b0;

        cmdRotPri = 1'b1;
        step(1);
        done_pulse();
        lock_pulse();
        check("rot_ptr1_ac", activeChannel, 2'd3);
        assertDACK = 1'b1;
        #1 check("dack_ch3", DACK, 4'b1000);
        #2 RESET_N = 1'b0;
        #1 check("arst_dack", DACK, 4'b0000);
        check("arst_cv", channelValid, 1'b0);
        check("arst_ac", activeChannel, 2'd0);
        check("arst_rp", requestPending, 1'b0);
        step(1);
        RESET_N = 1'b1;
        assertDACK = 1'b0;
        step(2);
        lock_pulse();
        check("arst_ptr0_ac", activeChannel, 2'd0);
        done_pulse();
        DREQ = 4'b1000;
        step(2);
        lock_pulse();
        check("post_rst_ch3", activeChannel, 2'd3);
        done_pulse();

`ifdef DMA_SW_REQUEST_EN
        DREQ = 4'b0000;
        maskReg = 4'b0100;
        step(2);
        swReqData = 3'b110;
        swReqWrite = 1'b1;
        step(1);
        swReqWrite = 1'b0;
        check("sw_reg_set", swReqReg, 4'b0100);
        check("sw_rp", requestPending, 1'b1);
        lock_pulse();
        check("sw_ac", activeChannel, 2'd2);
        intEOP = 1'b1;
        done_pulse();
        intEOP = 1'b0;
        check("sw_eop_clr", swReqReg, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
